// File: rtl/chan_mux_rr.sv
// N-channel valid/ready selector with fixed-select or round-robin grant and a one-entry output register.
// Optional build macro CHAN_MUX_ZERO_IDLE_EN zeroes out_data/out_ch whenever the output drains to idle.
module chan_mux_rr #(
    parameter int N_CH  = 6,
    parameter int WIDTH = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic [SEL_W-1:0] rr_ptr;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] gnt_data;
    int               rr_idx;

    assign load_en = !out_valid || out_ready;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        rr_idx  = 0;
        if (!mode) begin
            // An out-of-range select leaves every channel ineligible, so the output drains.
            if (int'(sel) < N_CH) begin
                grant[sel] = 1'b1;
                gnt_idx    = sel;
                gnt_any    = 1'b1;
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                rr_idx = (int'(rr_ptr) + k) % N_CH;
                if (!gnt_any && in_valid[rr_idx]) begin
                    grant[rr_idx] = 1'b1;
                    gnt_idx       = SEL_W'(rr_idx);
                    gnt_any       = 1'b1;
                end
            end
        end
    end

    assign gnt_data = in_data[gnt_idx*WIDTH +: WIDTH];
    assign in_ready = (rst_n && load_en) ? grant : '0;
    assign xfer     = gnt_any && load_en && in_valid[gnt_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_W'(N_CH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt_idx;
            if (mode) begin
                rr_ptr <= gnt_idx;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
`ifdef CHAN_MUX_ZERO_IDLE_EN
            out_data  <= '0;
            out_ch    <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_chan_mux_rr.sv
// Randomised and directed bench for chan_mux_rr against a behavioural model of the grant rules.
module tb_chan_mux_rr;

    localparam int N_CH  = 6;
    localparam int WIDTH = 4;
    localparam int SEL_W = $clog2(N_CH);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  mode = 1'b0;
    logic [SEL_W-1:0]      sel = '0;
    logic [N_CH-1:0]       in_valid = '0;
    logic [N_CH*WIDTH-1:0] in_data = '0;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_ready = 1'b0;

    chan_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: what the output register must hold, and the last round-robin winner.
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    int               m_ch    = 0;
    int               m_ptr   = N_CH - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = N_CH - 1;
    endtask

    // Channel the rules select this cycle, or -1 when none is eligible.
    function automatic int pick();
        int order[$];
        if (!mode) return (int'(sel) < N_CH) ? int'(sel) : -1;
        for (int k = 1; k <= N_CH; k++) order.push_back((m_ptr + k) % N_CH);
        foreach (order[j]) if (in_valid[order[j]]) return order[j];
        return -1;
    endfunction

    // One clock: compare everything against the model, then advance the model across the edge.
    task automatic cycle(output int granted);
        int               g;
        bit               load;
        bit               xfer;
        logic [N_CH-1:0]  exp_rdy;
        #1;
        load    = !m_valid || out_ready;
        g       = pick();
        exp_rdy = '0;
        if (g >= 0 && load) exp_rdy[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_ch", 32'(out_ch), 32'(m_ch));
        xfer    = (g >= 0) && load && in_valid[g];
        granted = xfer ? g : -1;
        @(posedge clk);
        if (xfer) begin
            m_valid = 1'b1;
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_ch    = g;
            if (mode) m_ptr = g;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
`ifdef CHAN_MUX_ZERO_IDLE_EN
            m_data  = '0;
            m_ch    = 0;
`endif
        end
        @(negedge clk);
    endtask

    task automatic data_is_index();
        for (int i = 0; i < N_CH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i);
    endtask

    initial begin
        int g;
        int prev;
        int exp_seq[8] = '{0, 1, 2, 3, 4, 5, 0, 1};

        // Reset held: outputs zero and no ready even with everything valid.
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Fixed mode, channel 3 with 4'hA.
        mode = 1'b0; sel = 3'd3; in_valid = 6'b001000; in_data = '0;
        in_data[3*WIDTH +: WIDTH] = 4'hA;
        #1 check("fixed_in_ready_lit", 32'(in_ready), 32'b001000);
        cycle(g);
        #1;
        check("fixed_out_valid_lit", 32'(out_valid), 32'd1);
        check("fixed_out_data_lit", 32'(out_data), 32'hA);
        check("fixed_out_ch_lit", 32'(out_ch), 32'd3);

        // Out-of-range select: nothing granted, output drains.
        sel = 3'd7; in_valid = '1; data_is_index();
        repeat (4) cycle(g);
        #1;
        check("oor_in_ready_lit", 32'(in_ready), 32'd0);
        check("oor_out_valid_lit", 32'(out_valid), 32'd0);
`ifdef CHAN_MUX_ZERO_IDLE_EN
        check("oor_zero_idle_lit", 32'(out_data), 32'd0);
`endif

        // Round-robin, all valid: 0..5,0,1 without bubbles.
        mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle(g);
            #1;
            check("rr_seq_lit", 32'(out_ch), 32'(exp_seq[k]));
            check("rr_no_bubble_lit", 32'(out_valid), 32'd1);
        end

        // Only channels 1 and 4, consumer toggling: beats alternate, ready all zero while held.
        in_valid = 6'b010010;
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            out_ready = (k % 2 == 0);
            #1;
            if (out_valid && !out_ready) check("held_in_ready_lit", 32'(in_ready), 32'd0);
            cycle(g);
            if (g >= 0) begin
                check("alt_is_1_or_4", 32'(g == 1 || g == 4), 32'd1);
                if (prev >= 0) check("alt_differs", 32'(g != prev), 32'd1);
                prev = g;
            end
        end
        out_ready = 1'b1;

        // Mode switch: reach last grant 2, fixed on 5, then round-robin resumes at 3.
        in_valid = '1;
        for (int k = 0; k < N_CH && m_ptr != 2; k++) cycle(g);
        check("ptr_reached_2", 32'(m_ptr), 32'd2);
        mode = 1'b0; sel = 3'd5;
        for (int k = 0; k < 3; k++) begin
            cycle(g);
            check("fixed_only_5_lit", 32'(g), 32'd5);
        end
        mode = 1'b1;
        cycle(g);
        check("rr_resume_3_lit", 32'(g), 32'd3);
        #1 check("rr_resume_out_ch_lit", 32'(out_ch), 32'd3);

        // Asynchronous reset mid-cycle with a beat held.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid_lit", 32'(out_valid), 32'd0);
        check("async_out_data_lit", 32'(out_data), 32'd0);
        check("async_out_ch_lit", 32'(out_ch), 32'd0);
        check("async_in_ready_lit", 32'(in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(g);
        check("post_reset_first_0_lit", 32'(g), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = SEL_W'($urandom_range(0, 7));
            in_valid  = N_CH'($urandom);
            in_data   = (N_CH*WIDTH)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chan_mux_rr.md
# chan_mux_rr

Parametrised N-channel, valid/ready selector that succeeds the combinational case-based data mux. It gathers up to N_CH producer channels onto one registered output stage. Each cycle it grants at most one channel, either by an external select (fixed mode) or by round-robin arbitration. It sits between per-channel producers and a single downstream consumer, and adds backpressure and a one-entry output register.

## Interface
- `N_CH`, default 6: number of input channels, 2..16.
- `WIDTH`, default 4: data width per channel.
- `SEL_W`, default `$clog2(N_CH)`: select and channel-ID width; derived, not overridden.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `mode`  input  1  0 = fixed select via `sel`; 1 = round-robin.
- `sel`  input  SEL_W  channel index used in fixed mode.
- `in_valid`  input  N_CH  per-channel valid.
- `in_data`  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  output  N_CH  per-channel ready; one-hot or zero.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  WIDTH  registered beat data.
- `out_ch`  output  SEL_W  index of the channel that produced the current beat.
- `out_ready`  input  1  consumer accepts the beat.

## Operation
- Output stage: one register, tracked by the `full` state, which equals `out_valid`.
- `load_en = !out_valid || out_ready`. The register may capture a beat this cycle only when `load_en` is high.
- Eligibility in fixed mode: only channel `sel` is eligible.
  - If `sel >= N_CH`, no channel is eligible.
  - The output then drains and stays empty. This is the successor to the old default-zero arm.
- Eligibility in round-robin mode:
  - Every channel with `in_valid` high is eligible.
  - The search starts at `rr_ptr + 1` modulo N_CH and picks the first eligible channel.
  - The wrap from N_CH-1 to 0 is required.
- Grant: `grant[i]` = channel i is the selected eligible channel. `in_ready[i] = grant[i] && load_en`.
- Transfer on channel i: `in_valid[i] && in_ready[i]`. On transfer:
  - `out_data <= in_data[i]`
  - `out_ch <= i`
  - `out_valid <= 1`
  - `rr_ptr <= i`, but only in round-robin mode.
- Consumption without refill: if `out_valid && out_ready` and no transfer happens this cycle, then `out_valid <= 0`.
- Simultaneous consume and refill in the same cycle: the register takes the new beat and `out_valid` stays 1. There is no bubble.
- `rr_ptr` is left unchanged by fixed-mode transfers. It is not reset on a mode change.
- Changes to `mode` or `sel` affect only the next grant decision. A beat already held in the register is never modified.
- Producers must hold `in_valid[i]` and `in_data[i]` until their transfer. The block does not check this.
- A held output beat (`out_valid && !out_ready`) keeps `out_data` and `out_ch` stable. All `in_ready` are 0 while it is held.

## Timing
- Reset (`rst_n` low, asynchronous, any cycle):
  - `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `rr_ptr = N_CH-1`, so channel 0 wins first.
  - `in_ready` is all zero while reset is asserted.
  - A beat in flight is discarded.
- Latency: one cycle from the input transfer edge to `out_valid` high with that beat.
- Throughput: one beat per cycle while `out_ready` is held 1 and an eligible channel is valid.
- `in_ready` is combinational from `out_valid`, `out_ready`, `in_valid`, `mode`, `sel` and `rr_ptr`.
- `out_*` signals are register outputs only, with no combinational path from the inputs.
- Round-robin fairness: with all N_CH channels continuously valid and `out_ready = 1`, grants cycle 0,1,...,N_CH-1,0,... and each channel gets exactly one grant per N_CH cycles.

## Configuration
- `CHAN_MUX_ZERO_IDLE_EN`:
  - Defined: `out_data` and `out_ch` are cleared to 0 on the same edge that `out_valid` goes 0 through consumption without refill. Idle output is always zero.
  - Undefined: `out_data` and `out_ch` keep the last beat while idle.
  - Handshake behaviour and timing are identical in both builds.

## Test plan
- Reset, then fixed mode, `sel = 3`, `in_valid[3] = 1`, data 4'hA, `out_ready = 1` -> `in_ready = 6'b001000`; next cycle `out_valid = 1`, `out_data = 4'hA`, `out_ch = 3`.
- Fixed mode, `sel = 7` (out of range), all valid -> `in_ready = 0` forever; `out_valid` drains to 0; with `CHAN_MUX_ZERO_IDLE_EN`, `out_data = 0`.
- Round-robin, all 6 channels valid with data = index, `out_ready = 1` for 8 cycles -> `out_ch` sequence 0,1,2,3,4,5,0,1; no bubbles.
- Round-robin, only channels 1 and 4 valid, `out_ready` toggling 1,0,1,0 -> beats alternate 1,4,1; `out_data` and `out_ch` are stable while `out_ready = 0`; all `in_ready` are 0 while the beat is held.
- Mid-stream `mode` switch from round-robin (last grant 2) to fixed `sel = 5`, then back to round-robin -> fixed beats come from channel 5 only; the first round-robin grant afterwards is channel 3 (pointer kept at 2).
- Assert `rst_n` low mid-cycle with `out_valid = 1` -> `out_valid`, `out_data` and `out_ch` go 0 immediately without waiting for `clk`; after release, the first round-robin grant is channel 0.
